// File: rtl/sga_pkg.sv
// Shared definitions for the sonar scheduler: state encoding, distance width
// and the saturating increment used by the centimetre counter.
package sga_pkg;

  localparam int DIST_W = 9;
  localparam logic [DIST_W-1:0] DIST_MAX = 9'd511;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_TRIG_E = 4'd1,
    S_WAIT_E = 4'd2,
    S_MEAS_E = 4'd3,
    S_GAP    = 4'd4,
    S_TRIG_D = 4'd5,
    S_WAIT_D = 4'd6,
    S_MEAS_D = 4'd7,
    S_DECIDE = 4'd8,
    S_DONE   = 4'd9
  } state_e;

  // Increment that sticks at DIST_MAX instead of wrapping.
  function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
    return (v == DIST_MAX) ? v : v + DIST_W'(1);
  endfunction

endpackage

// File: rtl/echo_meter.sv
// Shared echo-measurement engine. The scheduler tells it which phase the
// selected sensor is in (trigger / wait-for-echo / measuring) and feeds it the
// already-synchronized, already-muxed echo. The engine owns the trigger
// timer, the timeout timer and the cycle/cm counters.
module echo_meter
  import sga_pkg::*;
#(
  parameter int TRIGGER_CYCLES = 500,
  parameter int CYCLES_PER_CM  = 2941,
  parameter int TIMEOUT_CYCLES = 1500000
) (
  input  logic              gclk,
  input  logic              grst_n,
  input  logic              trig_i,       // trigger phase active
  input  logic              wait_i,       // waiting for echo rise
  input  logic              meas_i,       // echo high, counting
  input  logic              echo_i,       // synchronized echo
  output logic              trig_done_o,  // last trigger cycle
  output logic              rise_o,       // echo rise seen while waiting
  output logic              done_o,       // fall or timeout ends this sensor
  output logic              timeout_o,    // done_o was caused by timeout
  output logic [DIST_W-1:0] cm_o
);

  localparam int TW = $clog2(TRIGGER_CYCLES + 1);
  localparam int OW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW = $clog2(CYCLES_PER_CM + 1);
  localparam logic [TW-1:0] TRIG_LAST = TW'(TRIGGER_CYCLES - 1);
  localparam logic [OW-1:0] TMO_LAST  = OW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CYC_LAST  = CW'(CYCLES_PER_CM - 1);
  // The rise cycle itself is the first counted echo clock.
  localparam logic [CW-1:0]     CYC_FIRST = (CYCLES_PER_CM == 1) ? '0 : CW'(1);
  localparam logic [DIST_W-1:0] CM_FIRST  = (CYCLES_PER_CM == 1) ? DIST_W'(1) : '0;

  logic [TW-1:0]     trig_cnt_q, trig_cnt_d;
  logic [OW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [DIST_W-1:0] cm_q, cm_d;
  logic              echo_prev_q;
  logic              fall, tmo_hit, armed;

  // Edge detection, timers and cm counting.
  always_comb begin
    armed       = wait_i | meas_i;
    trig_done_o = trig_i && (trig_cnt_q == TRIG_LAST);
    rise_o      = wait_i && echo_i && !echo_prev_q;
    fall        = meas_i && !echo_i && echo_prev_q;
    tmo_hit     = armed && (tmo_cnt_q == TMO_LAST);
    // A real falling edge wins over a simultaneous timeout.
    done_o      = fall | tmo_hit;
    timeout_o   = tmo_hit & ~fall;
    trig_cnt_d  = trig_i ? trig_cnt_q + TW'(1) : '0;
    tmo_cnt_d   = armed ? tmo_cnt_q + OW'(1) : '0;
    cyc_d       = cyc_q;
    cm_d        = cm_q;
    if (rise_o) begin
      cyc_d = CYC_FIRST;
      cm_d  = CM_FIRST;
    end else if (meas_i && !fall) begin
      if (cyc_q == CYC_LAST) begin
        cyc_d = '0;
        cm_d  = sat_inc(cm_q);
      end else begin
        cyc_d = cyc_q + CW'(1);
      end
    end
  end

  // Counter state; echo_prev tracks continuously so a level already high on
  // entry to the wait phase is never mistaken for a rising edge.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      trig_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      cyc_q       <= '0;
      cm_q        <= '0;
      echo_prev_q <= 1'b0;
    end else begin
      trig_cnt_q  <= trig_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      cyc_q       <= cyc_d;
      cm_q        <= cm_d;
      echo_prev_q <= echo_i;
    end
  end

  assign cm_o = cm_q;

endmodule

// File: rtl/sonar_scheduler.sv
// Sequences the left then right ultrasonic sensors through one shared
// echo_meter, keeps the last distance per sensor and produces the
// left/right hand decision with a one-cycle pronto strobe.
module sonar_scheduler
  import sga_pkg::*;
#(
  parameter int TRIGGER_CYCLES = 500,
  parameter int CYCLES_PER_CM  = 2941,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int GAP_CYCLES     = 3000000,
  parameter int THRESHOLD_CM   = 20
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              medir,
  input  logic              echo_esq,
  input  logic              echo_dir,
  output logic              trigger_esq,
  output logic              trigger_dir,
  output logic [DIST_W-1:0] dist_esq,
  output logic [DIST_W-1:0] dist_dir,
  output logic              timeout_esq,
  output logic              timeout_dir,
  output logic              esq,
  output logic              dir,
  output logic              pronto,
  output logic              ocupado,
  output logic [3:0]        db_estado
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0]     GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [DIST_W-1:0] THR      = DIST_W'(THRESHOLD_CM);

  state_e            state_q, state_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [1:0]        sync_e_q, sync_d_q;
  logic [DIST_W-1:0] dist_esq_q, dist_dir_q;
  logic              tmo_esq_q, tmo_dir_q, esq_q, dir_q;
  logic              sel_dir, in_trig, in_wait, in_meas, echo_mux;
  logic              trig_done, rise, done, tmo;
  logic [DIST_W-1:0] cm;
  logic              near_e, near_d;

  // Two-flop synchronizers on the raw echo inputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_e_q <= '0;
      sync_d_q <= '0;
    end else begin
      sync_e_q <= {sync_e_q[0], echo_esq};
      sync_d_q <= {sync_d_q[0], echo_dir};
    end
  end

  // Phase decode and echo selection for the shared engine.
  always_comb begin
    sel_dir  = (state_q == S_TRIG_D) || (state_q == S_WAIT_D) || (state_q == S_MEAS_D);
    in_trig  = (state_q == S_TRIG_E) || (state_q == S_TRIG_D);
    in_wait  = (state_q == S_WAIT_E) || (state_q == S_WAIT_D);
    in_meas  = (state_q == S_MEAS_E) || (state_q == S_MEAS_D);
    echo_mux = sel_dir ? sync_d_q[1] : sync_e_q[1];
  end

  echo_meter #(
    .TRIGGER_CYCLES(TRIGGER_CYCLES),
    .CYCLES_PER_CM (CYCLES_PER_CM),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_meter (
    .gclk       (clock),
    .grst_n     (reset),
    .trig_i     (in_trig),
    .wait_i     (in_wait),
    .meas_i     (in_meas),
    .echo_i     (echo_mux),
    .trig_done_o(trig_done),
    .rise_o     (rise),
    .done_o     (done),
    .timeout_o  (tmo),
    .cm_o       (cm)
  );

  // Next-state logic and guard-gap timer.
  always_comb begin
    state_d   = state_q;
    gap_cnt_d = (state_q == S_GAP) ? gap_cnt_q + GW'(1) : '0;
    case (state_q)
      S_IDLE:   if (medir) state_d = S_TRIG_E;
      S_TRIG_E: if (trig_done) state_d = S_WAIT_E;
      S_WAIT_E: if (done) state_d = S_GAP;
                else if (rise) state_d = S_MEAS_E;
      S_MEAS_E: if (done) state_d = S_GAP;
      S_GAP:    if (gap_cnt_q == GAP_LAST) state_d = S_TRIG_D;
      S_TRIG_D: if (trig_done) state_d = S_WAIT_D;
      S_WAIT_D: if (done) state_d = S_DECIDE;
                else if (rise) state_d = S_MEAS_D;
      S_MEAS_D: if (done) state_d = S_DECIDE;
      S_DECIDE: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and gap counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    near_e = dist_esq_q < THR;
    near_d = dist_dir_q < THR;
  end

  // Per-sensor result registers and the steering decision.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dist_esq_q <= '0;
      dist_dir_q <= '0;
      tmo_esq_q  <= 1'b0;
      tmo_dir_q  <= 1'b0;
      esq_q      <= 1'b0;
      dir_q      <= 1'b0;
    end else begin
      if (done && !sel_dir && (in_wait || in_meas)) begin
        dist_esq_q <= tmo ? DIST_MAX : cm;
        tmo_esq_q  <= tmo;
      end
      if (done && sel_dir) begin
        dist_dir_q <= tmo ? DIST_MAX : cm;
        tmo_dir_q  <= tmo;
      end
      if (state_q == S_DECIDE) begin
        esq_q <= near_e & ~near_d;
        dir_q <= near_d & ~near_e;
      end
    end
  end

  assign trigger_esq = (state_q == S_TRIG_E);
  assign trigger_dir = (state_q == S_TRIG_D);
  assign dist_esq    = dist_esq_q;
  assign dist_dir    = dist_dir_q;
  assign timeout_esq = tmo_esq_q;
  assign timeout_dir = tmo_dir_q;
  assign esq         = esq_q;
  assign dir         = dir_q;
  assign pronto      = (state_q == S_DONE);
  assign ocupado     = (state_q != S_IDLE);
  assign db_estado   = state_q;

endmodule

// File: doc/sonar_scheduler.md
# sonar_scheduler

Sequences the two ultrasonic rangefinders (left/right hand sensors) that drive the snake's gesture steering. On each `medir` request it triggers the left sensor, measures its echo, waits a crosstalk guard gap, then does the same for the right sensor, sharing one echo-measurement engine between both. It converts both distances to centimetres and reports the `esq`/`dir` decision to the game control unit with a one-cycle `pronto` strobe.

## Interface
- `TRIGGER_CYCLES`, 500: trigger pulse width in clocks (10 µs at 50 MHz).
- `CYCLES_PER_CM`, 2941: echo clocks per centimetre.
- `TIMEOUT_CYCLES`, 1500000: maximum clocks from trigger fall to echo fall (30 ms).
- `GAP_CYCLES`, 3000000: guard time between the left and right measurements (60 ms).
- `THRESHOLD_CM`, 20: a hand counts as present when distance < threshold.

Ports:
- `clock` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `medir` in 1: measurement request; sampled only in IDLE.
- `echo_esq`, `echo_dir` in 1: asynchronous echo inputs.
- `trigger_esq`, `trigger_dir` out 1: sensor trigger pulses.
- `dist_esq`, `dist_dir` out 9: last distance in cm, saturating at 511.
- `timeout_esq`, `timeout_dir` out 1: the last measurement on that sensor timed out.
- `esq`, `dir` out 1: decision, held until the next `pronto`.
- `pronto` out 1: one-cycle strobe when a measurement cycle ends.
- `ocupado` out 1: high from the cycle after `medir` is accepted until the `pronto` cycle, inclusive.
- `db_estado` out 4: current state encoding, for debug.

## Operation
- **States:** IDLE(0), TRIG_E(1), WAIT_E(2), MEAS_E(3), GAP(4), TRIG_D(5), WAIT_D(6), MEAS_D(7), DECIDE(8), DONE(9).
- **Echo synchronisation:** each echo input passes through a 2-FF synchronizer. Edge detection uses only the synchronized signal.
- **IDLE → TRIG_E:** when `medir`=1. A `medir` pulse in any other state is ignored; there is no queuing.
- **TRIG_x:** `trigger_x`=1 for exactly TRIGGER_CYCLES clocks, then go to WAIT_x. The timeout counter starts at the trigger falling edge.
- **WAIT_x:** wait for a synchronized rising edge on `echo_x`, then go to MEAS_x.
  - An echo already high on entry is not an edge; the engine must see it fall and rise again.
- **MEAS_x:** a cycle counter wraps at CYCLES_PER_CM, and each wrap increments the cm counter, which saturates at 511.
  - On a synchronized falling edge, latch the cm count into `dist_x` and clear `timeout_x`.
- **Timeout:** applies in WAIT_x or MEAS_x. When the timeout counter reaches TIMEOUT_CYCLES:
  - `dist_x` is set to 511 and `timeout_x` to 1.
  - The state advances exactly as it does after a falling edge.
- **After each sensor:** MEAS_E/timeout goes to GAP, which holds for GAP_CYCLES and then goes to TRIG_D. MEAS_D/timeout goes to DECIDE.
- **DECIDE:** let near_e = `dist_esq` < THRESHOLD_CM and near_d = `dist_dir` < THRESHOLD_CM.
  - `esq` = near_e & ~near_d.
  - `dir` = near_d & ~near_e.
  - If both are near or neither is near, both outputs are 0.
- **DONE:** `pronto`=1 for one cycle, then return to IDLE.
- **Mid-operation reset:** aborts immediately; both triggers drop in the same instant.

## Timing
- **Reset values:** every output is 0, including `dist_*`, `timeout_*`, `esq`, `dir`, `pronto`, `ocupado` and `db_estado`; the state is IDLE.
- **Trigger latency:** `medir` high at edge k puts `trigger_esq` high from edge k+1 through edge k+TRIGGER_CYCLES.
- **Echo latency:** 2 clocks of synchronizer delay are added to both edges, so the measured width is unchanged.
- **Outputs:** `dist_x`/`timeout_x` update at the clock on which the falling edge or timeout is detected. `esq`/`dir` update in DECIDE, one cycle before `pronto`.
- **Minimum cycle length:** 2·TRIGGER_CYCLES + GAP_CYCLES + 2 echo widths + about 8 clocks.
- **Trigger exclusivity:** `trigger_esq` and `trigger_dir` are never high together.

## Structure
- **Shared package** (`sga_pkg`): state encoding constants, the 9-bit distance width, and the saturation value 511.
- **Sub-module `echo_meter`:** a single instance, shared between the sensors.
  - Inputs: start, synchronized echo (muxed by the scheduler).
  - Outputs: done, cm count, timeout.
  - Contains the trigger timer, timeout timer and cm counters.
- **Scheduler:** owns the FSM, the echo/trigger muxing, the distance registers and the decision logic.

## Test plan
Bench parameters for all scenarios: TRIGGER_CYCLES=10, CYCLES_PER_CM=4, TIMEOUT_CYCLES=400, GAP_CYCLES=20, THRESHOLD_CM=20.

1. **Basic measurement:**
   - Stimulus: `medir` pulse; `echo_esq` high for 40 clocks; `echo_dir` high for 200 clocks.
   - Required: `trigger_esq` is exactly 10 clocks wide; `dist_esq`=10 and `dist_dir`=50; `esq`=1, `dir`=0; `pronto` is a single cycle.
2. **Timeout:**
   - Stimulus: no echo on the right sensor.
   - Required: `dist_dir`=511, `timeout_dir`=1, and `pronto` occurs about 400 clocks after the trigger falls.
3. **Both hands near:**
   - Stimulus: both echoes 20 clocks wide (5 cm).
   - Required: `esq`=`dir`=0.
4. **Busy and stuck echo:**
   - Stimulus: a `medir` pulse during GAP, and `echo_esq` stuck high before the trigger.
   - Required: the extra `medir` is ignored, so only one `pronto` occurs; the left sensor times out.
5. **Saturation:**
   - Stimulus: an echo width of 2100 clocks, with TIMEOUT raised to 5000.
   - Required: `dist`=511 and `timeout`=0.
6. **Reset during TRIG_D:**
   - Stimulus: assert `reset` while in TRIG_D.
   - Required: all outputs are 0 asynchronously, and the next `medir` restarts from the left sensor.
